// File: rtl/image_sprite_writer.sv
// Captures one framed RGB pixel stream into an image BRAM as 8-bit palette keys.
// Define IMAGE_SPRITE_WRITER_RGB332_EN to derive each key from the pixel as RGB332.
module image_sprite_writer #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic                              pixel_clk_in,
    input  logic                              rst_n_in,
    input  logic                              start_in,
    input  logic                              pixel_valid_in,
    output logic                              pixel_ready_out,
    input  logic [23:0]                       pixel_data_in,
    input  logic                              pixel_sof_in,
    input  logic                              pixel_eol_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr_out,
    output logic [7:0]                        wr_data_out,
    output logic                              wr_en_out,
    output logic                              busy_out,
    output logic                              frame_done_out,
    output logic                              err_out
);

    localparam int AW = $clog2(WIDTH*HEIGHT);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [31:0] C_WIDTH  = 32'(WIDTH);
    localparam logic [31:0] C_HEIGHT = 32'(HEIGHT);
    localparam logic [31:0] C_PIXELS = 32'(WIDTH*HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XW-1:0]   r_x;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   r_y;
    logic [YW-1:0]   w_y_nxt;
    logic            r_ready;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_err;
    logic            r_frame_done;

    logic            w_xfer;
    logic            w_last_col;
    logic            w_last_row;
    logic            w_in_range;
    logic [31:0]     w_addr_full;
    logic            w_wr;
    logic [AW-1:0]   w_wr_addr;
    logic            w_err;
    logic [7:0]      w_key;
    logic            w_unused_pixel_bits;

    assign w_xfer      = pixel_valid_in & r_ready;
    assign w_addr_full = 32'(r_y) * C_WIDTH + 32'(r_x);
    assign w_last_col  = (32'(r_x) == C_WIDTH - 32'd1);
    assign w_last_row  = (32'(r_y) == C_HEIGHT - 32'd1);
    assign w_in_range  = (32'(r_x) < C_WIDTH) && (w_addr_full < C_PIXELS);

`ifdef IMAGE_SPRITE_WRITER_RGB332_EN
    assign w_key = {pixel_data_in[23:21], pixel_data_in[15:13], pixel_data_in[7:6]};
`else
    assign w_key = pixel_data_in[7:0];
`endif
    assign w_unused_pixel_bits = ^pixel_data_in;

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_wr        = 1'b0;
        w_wr_addr   = '0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_xfer && pixel_sof_in) begin
                    w_wr        = 1'b1;
                    w_x_nxt     = XW'(1);
                    w_y_nxt     = '0;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_xfer) begin
                    if (pixel_sof_in) begin
                        // Restart: the sof pixel becomes pixel 0 of a fresh frame.
                        w_err   = 1'b1;
                        w_wr    = 1'b1;
                        w_x_nxt = XW'(1);
                        w_y_nxt = '0;
                    end else if ((pixel_eol_in != w_last_col) || !w_in_range) begin
                        w_err       = 1'b1;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_state_nxt = S_ARMED;
                    end else begin
                        w_wr      = 1'b1;
                        w_wr_addr = w_addr_full[AW-1:0];
                        if (w_last_col) begin
                            w_x_nxt = '0;
                            if (w_last_row) begin
                                w_y_nxt     = '0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_y_nxt = r_y + YW'(1);
                            end
                        end else begin
                            w_x_nxt = r_x + XW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_ready      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_ready      <= 1'b1;
            r_wr_en      <= w_wr;
            r_err        <= w_err;
            r_frame_done <= (r_state == S_DONE);
            if (w_wr) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_key;
            end
        end
    end

    assign pixel_ready_out = r_ready;
    assign wr_en_out       = r_wr_en;
    assign wr_addr_out     = r_wr_addr;
    assign wr_data_out     = r_wr_data;
    assign err_out         = r_err;
    assign frame_done_out  = r_frame_done;
    assign busy_out        = (r_state == S_ARMED) || (r_state == S_CAPTURE);

endmodule

// File: doc/image_sprite_writer.md
IMAGE_SPRITE_WRITER -- requirements
Module: image_sprite_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 256, sprite width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 256, sprite height in lines.
REQ-003 pixel_clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 start_in  input  1  one-cycle pulse arming capture of one frame.
REQ-006 pixel_valid_in  input  1  upstream pixel valid.
REQ-007 pixel_ready_out  output  1  pixel accept; transfer = valid && ready.
REQ-008 pixel_data_in  input  24  RGB888 pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-009 pixel_sof_in  input  1  marks first pixel of frame.
REQ-010 pixel_eol_in  input  1  marks last pixel of line.
REQ-011 wr_addr_out  output  $clog2(WIDTH*HEIGHT)  image BRAM write address.
REQ-012 wr_data_out  output  8  palette key written to image BRAM.
REQ-013 wr_en_out  output  1  image BRAM write enable.
REQ-014 busy_out  output  1  high in ARMED or CAPTURE.
REQ-015 frame_done_out  output  1  one-cycle pulse on complete frame.
REQ-016 err_out  output  1  one-cycle pulse on framing error.

Function
REQ-017 States: IDLE, ARMED, CAPTURE, DONE; pixel_ready_out SHALL be 1 in every state out of reset (stream never stalled); transfers outside CAPTURE/ARMED-with-sof are discarded, no write.
REQ-018 IDLE -> ARMED on start_in; start_in ignored in ARMED, CAPTURE, DONE.
REQ-019 ARMED: transfer with pixel_sof_in SHALL write address 0, set x=1, y=0, go CAPTURE; transfers without sof discarded.
REQ-020 CAPTURE: each transfer writes address y*WIDTH+x, then x increments; at x=WIDTH-1 with eol, x wraps to 0 and y increments.
REQ-021 Write latency SHALL be exactly 1 cycle: wr_en_out, wr_addr_out, wr_data_out registered, valid the cycle after the transfer; wr_en_out low otherwise.
REQ-022 Transfer at x=WIDTH-1, y=HEIGHT-1 with eol SHALL be written, then state DONE for one cycle with frame_done_out=1, then IDLE.
REQ-023 Error (eol at x!=WIDTH-1, or x=WIDTH-1 without eol): pixel NOT written, err_out pulses next cycle, state returns ARMED.
REQ-024 sof during CAPTURE: err_out pulses, pixel written to address 0, x=1, y=0, stay CAPTURE (restart frame).
REQ-025 Address arithmetic SHALL be computed at full width then truncated to wr_addr_out width; no address beyond WIDTH*HEIGHT-1 SHALL be written.
REQ-026 Valid low in any state: no state/counter change.

Reset
REQ-027 rst_n_in low SHALL immediately force IDLE, x=y=0, and all outputs 0 (pixel_ready_out, wr_en_out, wr_addr_out, wr_data_out, busy_out, frame_done_out, err_out).
REQ-028 Reset mid-CAPTURE SHALL abandon frame with no frame_done_out or err_out; a new start_in is required after release.

Configuration
REQ-029 Macro IMAGE_SPRITE_WRITER_RGB332_EN defined: wr_data_out = {R[7:5],G[7:5],B[7:6]} of the pixel.
REQ-030 Macro undefined: wr_data_out = pixel_data_in[7:0] (upstream supplies palette key); all other behaviour identical.

Verification (WIDTH=4, HEIGHT=2, macro undefined unless noted)
REQ-031 Reset, start, 8 valid pixels data 0..7, sof on first, eol on 4th/8th -> writes addr 0..7 data 0..7, frame_done_out pulse 1 cycle after last write cycle, busy_out low after.
REQ-032 Pixels before start_in, or after start without sof -> wr_en_out never asserts, busy_out tracks ARMED.
REQ-033 eol on 3rd pixel of line 0 -> pixel not written, err_out 1 cycle, next sof frame captures cleanly from addr 0.
REQ-034 sof on 6th pixel -> err_out pulse, that pixel written to addr 0, frame completes 8 pixels later.
REQ-035 rst_n_in low after 5th pixel -> outputs 0 asynchronously, no frame_done_out; later frame without new start_in -> no writes.
REQ-036 Macro defined, pixel 24'hFF8040 -> wr_data_out 8'hF1 ({111,100,01}).
